// File: rtl/sm4_linear_pipe.sv
// SM4 linear transform pipeline: L' (mode 0, key schedule) or L (mode 1, round) on LANES words per beat.
// Latency STAGES edges; valid/ready backpressure with a combinational ready chain; clr flushes in-flight beats.
module sm4_linear_pipe #(
  parameter int WORD_WIDTH = 32,
  parameter int LANES      = 1,
  parameter int STAGES     = 1,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_mode,
  input  logic [LANES*WORD_WIDTH-1:0]        in_data,
  input  logic [TAG_WIDTH-1:0]               in_tag,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES*WORD_WIDTH-1:0]        out_data,
  output logic [TAG_WIDTH-1:0]               out_tag,
  output logic                               out_mode,
  output logic [$clog2(STAGES+1)-1:0]        occupancy
);

  localparam int DW = LANES * WORD_WIDTH;
  localparam int OW = $clog2(STAGES + 1);

  // Rotation amounts are fixed by SM4, so any other word width is meaningless.
  if (WORD_WIDTH != 32) begin : g_bad_width
    $error("sm4_linear_pipe: WORD_WIDTH must be 32");
  end
  if (LANES < 1 || LANES > 8) begin : g_bad_lanes
    $error("sm4_linear_pipe: LANES must be 1..8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("sm4_linear_pipe: STAGES must be 1..4");
  end
  if (TAG_WIDTH < 1 || TAG_WIDTH > 16) begin : g_bad_tag
    $error("sm4_linear_pipe: TAG_WIDTH must be 1..16");
  end

  logic [DW-1:0] lin_dat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0] x;
    logic [31:0] y_key;
    logic [31:0] y_rnd;
    assign x     = in_data[32*i +: 32];
    assign y_key = x ^ {x[18:0], x[31:19]} ^ {x[8:0], x[31:9]};
    assign y_rnd = x ^ {x[29:0], x[31:30]} ^ {x[21:0], x[31:22]}
                     ^ {x[13:0], x[31:14]} ^ {x[7:0], x[31:8]};
    assign lin_dat[32*i +: 32] = in_mode ? y_rnd : y_key;
  end

  logic [STAGES-1:0]    vld_q, vld_d;
  logic [STAGES-1:0]    mode_q, mode_d;
  logic [STAGES-1:0]    rdy;
  logic [DW-1:0]        dat_q [STAGES];
  logic [DW-1:0]        dat_d [STAGES];
  logic [TAG_WIDTH-1:0] tag_q [STAGES];
  logic [TAG_WIDTH-1:0] tag_d [STAGES];

  // Stage k may move when out_ready is high or any stage from k to the output is empty.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc    = acc || !vld_q[k];
      rdy[k] = acc;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    dat_d  = dat_q;
    tag_d  = tag_q;
    if (rdy[0]) begin
      vld_d[0]  = in_valid;
      mode_d[0] = in_mode;
      dat_d[0]  = lin_dat;
      tag_d[0]  = in_tag;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (rdy[k]) begin
        vld_d[k]  = vld_q[k-1];
        mode_d[k] = mode_q[k-1];
        dat_d[k]  = dat_q[k-1];
        tag_d[k]  = tag_q[k-1];
      end
    end
    if (clr) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dat_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      for (int k = 0; k < STAGES; k++) begin
        dat_q[k] <= dat_d[k];
        tag_q[k] <= tag_d[k];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OW'(vld_q[k]);
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = dat_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];

endmodule

// File: tb/tb_sm4_linear_pipe.sv
// Bench for sm4_linear_pipe: a 1-lane/1-stage and a 4-lane/3-stage instance checked against
// a queue-based transaction model every cycle, plus literal vectors.
module tb_sm4_linear_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
  logic [31:0] a_in_data, a_out_data;
  logic [3:0]  a_in_tag, a_out_tag;
  logic [0:0]  a_occ;

  logic         b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
  logic [127:0] b_in_data, b_out_data;
  logic [3:0]   b_in_tag, b_out_tag;
  logic [1:0]   b_occ;

  sm4_linear_pipe #(.WORD_WIDTH(32), .LANES(1), .STAGES(1), .TAG_WIDTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .in_data(a_in_data), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .out_mode(a_out_mode), .occupancy(a_occ));

  sm4_linear_pipe #(.WORD_WIDTH(32), .LANES(4), .STAGES(3), .TAG_WIDTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .out_mode(b_out_mode), .occupancy(b_occ));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] lin(input logic [31:0] x, input logic m);
    if (m) return x ^ rl(x, 2) ^ rl(x, 10) ^ rl(x, 18) ^ rl(x, 24);
    return x ^ rl(x, 13) ^ rl(x, 23);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] x, input logic m, input int lanes);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < lanes; i++) y[32*i +: 32] = lin(x[32*i +: 32], m);
    return y;
  endfunction

  // Transaction model: in-flight beats in acceptance order, with the acceptance cycle.
  typedef struct {
    logic [127:0] d;
    logic [3:0]   tag;
    logic         mode;
    int           acc;
  } beat_t;

  beat_t mbuf [2][64];
  int hd [2] = '{0, 0};
  int tl [2] = '{0, 0};
  int cyc = 0;
  int st [2] = '{1, 3};
  int ln [2] = '{1, 4};

  logic [127:0] s_od [2], s_id [2];
  logic         s_ov [2], s_om [2], s_ir [2], s_iv [2], s_or [2], s_im [2];
  logic [3:0]   s_ot [2], s_it [2];
  int           s_occ [2];
  int           cnt;
  logic         ev, er;

  always @(negedge clk) begin
    s_od[0] = 128'(a_out_data); s_ov[0] = a_out_valid; s_om[0] = a_out_mode; s_ot[0] = a_out_tag;
    s_ir[0] = a_in_ready; s_iv[0] = a_in_valid; s_or[0] = a_out_ready; s_im[0] = a_in_mode;
    s_id[0] = 128'(a_in_data); s_it[0] = a_in_tag; s_occ[0] = int'(a_occ);
    s_od[1] = b_out_data; s_ov[1] = b_out_valid; s_om[1] = b_out_mode; s_ot[1] = b_out_tag;
    s_ir[1] = b_in_ready; s_iv[1] = b_in_valid; s_or[1] = b_out_ready; s_im[1] = b_in_mode;
    s_id[1] = b_in_data; s_it[1] = b_in_tag; s_occ[1] = int'(b_occ);
    for (int d = 0; d < 2; d++) begin
      cnt = tl[d] - hd[d];
      if (!rst_n) begin
        chk($sformatf("dut%0d rst out_valid", d), s_ov[d], 0);
        chk($sformatf("dut%0d rst out_data", d), s_od[d], 0);
        chk($sformatf("dut%0d rst occupancy", d), s_occ[d], 0);
        chk($sformatf("dut%0d rst in_ready", d), s_ir[d], 1);
        hd[d] = 0;
        tl[d] = 0;
      end else begin
        // The oldest beat has nothing ahead of it, so it reaches the output exactly STAGES cycles in.
        ev = (cnt > 0) && (cyc - mbuf[d][hd[d] % 64].acc >= st[d]);
        er = !(cnt == st[d] && !s_or[d]);
        chk($sformatf("dut%0d out_valid", d), s_ov[d], ev);
        if (ev) begin
          chk($sformatf("dut%0d out_data", d), s_od[d], mbuf[d][hd[d] % 64].d);
          chk($sformatf("dut%0d out_tag", d), s_ot[d], mbuf[d][hd[d] % 64].tag);
          chk($sformatf("dut%0d out_mode", d), s_om[d], mbuf[d][hd[d] % 64].mode);
        end
        chk($sformatf("dut%0d occupancy", d), s_occ[d], cnt);
        chk($sformatf("dut%0d in_ready", d), s_ir[d], er);
        if (clr) begin
          hd[d] = tl[d];
        end else begin
          if (ev && s_or[d]) hd[d]++;
          if (s_iv[d] && er) begin
            mbuf[d][tl[d] % 64] = '{model(s_id[d], s_im[d], ln[d]), s_it[d], s_im[d], cyc};
            tl[d]++;
          end
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0]  vx [6];
  logic [31:0]  vy [6];
  logic         vm [6];
  logic [127:0] exp_b;
  int           acc_cnt;
  int           k;
  logic         take;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vx = '{32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h00000000};
    vy = '{32'h00802001, 32'h80401000, 32'hFFFFFFFF, 32'h01040405, 32'h80820202, 32'h00000000};
    vm = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_in_tag = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1;
    #2;
    chk("init a out_valid", a_out_valid, 0);
    chk("init a in_ready", a_in_ready, 1);
    chk("init b out_data", b_out_data, 0);
    chk("init b occupancy", b_occ, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    // Literal vectors, one edge of latency
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1; a_in_mode = vm[i]; a_in_data = vx[i]; a_in_tag = 4'(i);
      tick();
      chk("vec out_valid", a_out_valid, 1);
      chk("vec out_data", a_out_data, vy[i]);
      chk("vec out_tag", a_out_tag, 4'(i));
      chk("vec out_mode", a_out_mode, vm[i]);
    end
    a_in_valid = 0;
    tick();

    // Reset in the middle of a stream
    a_in_valid = 1; a_in_mode = 0; a_in_data = 32'h12345678; a_in_tag = 4'h7;
    tick();
    #1 rst_n = 0;
    #1;
    chk("midrst out_valid", a_out_valid, 0);
    chk("midrst out_data", a_out_data, 0);
    chk("midrst out_tag", a_out_tag, 0);
    chk("midrst occupancy", a_occ, 0);
    chk("midrst in_ready", a_in_ready, 1);
    a_in_valid = 0;
    tick();
    rst_n = 1;
    tick();
    chk("postrst out_valid", a_out_valid, 0);

    // Multi-lane literal, latency 3
    b_in_valid = 1; b_in_mode = 0; b_in_tag = 4'hA;
    b_in_data = {32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000001};
    exp_b     = {32'h80401000, 32'hFFFFFFFF, 32'h80401000, 32'h00802001};
    tick();
    b_in_valid = 0;
    tick();
    chk("b lat early out_valid", b_out_valid, 0);
    tick();
    chk("b lat out_valid", b_out_valid, 1);
    chk("b lat out_data", b_out_data, exp_b);
    chk("b lat out_tag", b_out_tag, 4'hA);
    tick();

    // Back-to-back mixed-mode stream, tags 0..15
    for (int i = 0; i < 16; i++) begin
      b_in_valid = 1; b_in_mode = i[0]; b_in_tag = 4'(i);
      b_in_data = {32'(i) * 32'h01010101, 32'h1 << i, ~(32'h1 << i), 32'hDEAD0000 | 32'(i)};
      tick();
    end
    b_in_valid = 0;
    repeat (5) tick();

    // Backpressure for 10 cycles with in_valid held high
    b_out_ready = 0; acc_cnt = 0; k = 0;
    for (int c = 0; c < 10; c++) begin
      b_in_valid = 1; b_in_mode = k[0]; b_in_tag = 4'(k + 3);
      b_in_data = {4{32'h0F0F0000 | 32'(k)}};
      @(negedge clk);
      take = b_in_ready;
      tick();
      if (take) begin
        acc_cnt++;
        k++;
      end
    end
    chk("bp accepted", acc_cnt, 3);
    chk("bp in_ready", b_in_ready, 0);
    chk("bp occupancy", b_occ, 3);
    b_in_valid = 0; b_out_ready = 1;
    repeat (6) tick();

    // Flush with two beats in flight and an offered beat
    b_in_valid = 1; b_in_mode = 0; b_in_tag = 4'h1; b_in_data = {4{32'h11111111}};
    tick();
    b_in_tag = 4'h2; b_in_data = {4{32'h22222222}};
    tick();
    clr = 1; b_in_tag = 4'h3; b_in_data = {4{32'h33333333}};
    tick();
    clr = 0; b_in_valid = 0;
    chk("flush occupancy", b_occ, 0);
    chk("flush out_valid", b_out_valid, 0);
    repeat (4) tick();

    b_in_valid = 1; b_in_mode = 1; b_in_tag = 4'h9; b_in_data = {96'h0, 32'h00000001};
    tick();
    b_in_valid = 0;
    tick(); tick();
    chk("postflush out_valid", b_out_valid, 1);
    chk("postflush out_data", b_out_data, {96'h0, 32'h01040405});
    chk("postflush out_tag", b_out_tag, 4'h9);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm4_linear_pipe.md
# sm4_linear_pipe

Parameterised, handshaked pipeline for the SM4 linear transforms. Each beat selects one of two transforms: L' for key expansion or L for the round function. The block processes LANES independent 32-bit words per beat through STAGES register stages with full valid/ready backpressure. It replaces the fixed single-cycle key-only L' stage and sits between the S-box (tau) stage and the round/key XOR stage of both the cipher datapath and the key schedule.

## Interface
- WORD_WIDTH, 32, word width; only 32 is legal because the rotation amounts are fixed by SM4. Elaboration must fail otherwise.
- LANES, 1, words processed in parallel per beat; legal range 1..8.
- STAGES, 1, pipeline register stages; legal range 1..4.
- TAG_WIDTH, 4, sideband tag carried unchanged alongside each beat; legal range 1..16.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous flush of all in-flight beats.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_mode  input  1  0 = L' (key), 1 = L (cipher).
- in_data  input  LANES*32  lane i occupies bits [32i+31:32i].
- in_tag  input  TAG_WIDTH  sideband tag.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  LANES*32  transformed words, in the same lane order as the input.
- out_tag  output  TAG_WIDTH  tag of the output beat.
- out_mode  output  1  mode of the output beat.
- occupancy  output  clog2(STAGES+1)  number of valid stages.

## Operation
- Per lane, with rotl meaning rotate-left on 32 bits:
  - mode 0: y = x ^ rotl(x,13) ^ rotl(x,23).
  - mode 1: y = x ^ rotl(x,2) ^ rotl(x,10) ^ rotl(x,18) ^ rotl(x,24).
- Lanes are fully independent; there is no carry or interaction between lanes.
- The transform is computed combinationally in front of stage 0. Stages 1..STAGES-1 carry the result, tag and mode unchanged; they exist for timing closure only.
- Each stage k holds valid_k, data_k, tag_k and mode_k.
- Handshake chain:
  - ready_STAGES = out_ready.
  - ready_k = !valid_k || ready_(k+1).
  - in_ready = ready_0.
  - out_valid = valid_(STAGES-1).
- When ready_k is 1:
  - stage k loads the contents of stage k-1; stage 0 loads from the input.
  - valid_k takes valid_(k-1), or in_valid for stage 0.
  - If ready_k is 0, stage k holds its contents.
- A beat is accepted when in_valid && in_ready, and consumed when out_valid && out_ready.
- While out_valid=1 and out_ready=0, out_data, out_tag and out_mode must stay stable.
- Data, tag and mode registers of invalid stages keep their old values; they need not be cleared.
- occupancy = popcount(valid_0..valid_(STAGES-1)).
- clr=1:
  - All valid bits go to 0 at the next edge.
  - Any input beat offered in that cycle is discarded, even though in_ready may show 1.
  - clr has priority over every other event.
- Reset (rst_n=0), applied immediately and asynchronously:
  - all valid_k = 0, all data/tag/mode registers = 0.
  - Hence out_valid=0, out_data=0, out_tag=0, out_mode=0, occupancy=0.
  - in_ready=1 during reset, since it is derived combinationally from the cleared valid bits.
- Reset in mid-operation drops all beats in flight; no partial beat may appear after reset is released.

## Timing
- Latency: a beat accepted at edge n is presented on out_valid after edge n+STAGES-1, and is visible in the cycle following edge n when STAGES=1.
- Stated uniformly: the output appears STAGES edges after acceptance, counting the acceptance edge.
- Throughput: one beat per cycle while out_ready=1; no bubbles are inserted.
- Full pipeline with out_ready=0: in_ready=0 combinationally in the same cycle. occupancy=STAGES.
- Simultaneous accept and consume on a full pipeline: both occur, and occupancy is unchanged.
- When out_ready rises, in_ready rises in the same cycle (a combinational ready path).
- No combinational path from in_valid or in_data to the outputs.
- Beats leave in the order they were accepted; there is no reordering.

## Test plan
- Reset values: with LANES=1 and STAGES=1, assert rst_n=0 mid-stream -> out_valid=0, out_data=0 and occupancy=0 immediately; in_ready=1.
- Mode 0 vectors (LANES=1, STAGES=1, out_ready=1):
  - 0x00000001 -> 0x00802001
  - 0x80000000 -> 0x80401000
  - 0xFFFFFFFF -> 0xFFFFFFFF
  - each output appears one edge after acceptance.
- Mode 1 vectors, same configuration:
  - 0x00000001 -> 0x01040405
  - 0x80000000 -> 0x80820202
  - 0x00000000 -> 0x00000000
- Multi-lane, mixed mode (LANES=4, STAGES=3): send a back-to-back stream that alternates mode 0 and mode 1 beats with tags 0..15.
  - Required: each output appears 3 edges after its acceptance, tags come out in order, and each lane matches the per-lane model.
- Backpressure (STAGES=3): hold out_ready=0 for 10 cycles with in_valid=1.
  - Required: exactly 3 beats accepted, then in_ready=0 and occupancy=3, with outputs stable throughout.
  - Release out_ready: 1 beat per cycle, no loss or duplication.
- Flush: with 2 beats in flight, assert clr for 1 cycle while in_valid=1.
  - Required: occupancy=0 on the next cycle, and the offered beat is not delivered.
  - A subsequent beat is delivered with normal latency.
